// File: rtl/except_commit.sv
// Write-back exception commit: registers the MEM instruction, prioritises its exception and pending interrupt, and drives cp0 commit and flush.
// Optional feature macro: EXCEPT_COMMIT_INT_EN enables the interrupt latch and the Int exception.
module except_commit #(
  parameter logic [31:0] EX_VEC_BEV1 = 32'hBFC00380,
  parameter logic [31:0] EX_VEC_BEV0 = 32'h80000180
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic        mem_eret,
  input  logic        mem_mtc0,
  input  logic [7:0]  mem_c0_addr,
  input  logic [31:0] mem_c0_wdata,
  input  logic [6:0]  mem_ex,
  input  logic [31:0] mem_badvaddr,
  input  logic        wb_stall,
  input  logic        c0_status_ie,
  input  logic        c0_status_exl,
  input  logic        c0_status_bev,
  input  logic [7:0]  c0_status_im,
  input  logic [7:0]  c0_cause_ip,
  input  logic [31:0] c0_epc,
  output logic        wb_except,
  output logic [4:0]  wb_excode,
  output logic        wb_bd,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_badvaddr,
  output logic        wb_badvaddr_we,
  output logic        eret_flush,
  output logic        mtc0_we,
  output logic [7:0]  c0_addr,
  output logic [31:0] c0_wdata,
  output logic        flush,
  output logic [31:0] flush_target,
  output logic        dbg_state
);

  typedef enum logic {RUN = 1'b0, DRAIN = 1'b1} state_t;
  state_t state, state_next;
  logic   drain;

  logic        wb_valid_q, wb_bd_q, wb_eret_q, wb_mtc0_q;
  logic [31:0] wb_pc_q, wb_wdata_q, wb_badvaddr_q;
  logic [7:0]  wb_c0_addr_q;
  logic [6:0]  wb_ex_q;
  logic        int_pend;

  logic        commit, has_ex, bv_we;
  logic [4:0]  excode;
  logic [31:0] bv;

  // Handshake: an instruction moves MEM->WB on every edge where wb_stall is low;
  // WB commits in the cycle it is valid and wb_stall is low.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_valid_q    <= 1'b0;
      wb_pc_q       <= '0;
      wb_bd_q       <= 1'b0;
      wb_eret_q     <= 1'b0;
      wb_mtc0_q     <= 1'b0;
      wb_c0_addr_q  <= '0;
      wb_wdata_q    <= '0;
      wb_ex_q       <= '0;
      wb_badvaddr_q <= '0;
    end else if (!wb_stall) begin
      wb_valid_q    <= mem_valid & ~flush & ~drain;
      wb_pc_q       <= mem_pc;
      wb_bd_q       <= mem_bd;
      wb_eret_q     <= mem_eret;
      wb_mtc0_q     <= mem_mtc0;
      wb_c0_addr_q  <= mem_c0_addr;
      wb_wdata_q    <= mem_c0_wdata;
      wb_ex_q       <= mem_ex;
      wb_badvaddr_q <= mem_badvaddr;
    end
  end

`ifdef EXCEPT_COMMIT_INT_EN
  logic int_cond;
  assign int_cond = c0_status_ie & ~c0_status_exl & (|(c0_cause_ip & c0_status_im));

  // Re-arms on its own if the condition persists after a flush; cp0 sets EXL by then.
  always_ff @(posedge clk) begin
    if (reset) int_pend <= 1'b0;
    else       int_pend <= int_cond & ~flush;
  end
`else
  logic unused_int;
  assign unused_int = ^{c0_status_ie, c0_status_exl, c0_status_im, c0_cause_ip};
  assign int_pend   = 1'b0;
`endif

  assign commit = wb_valid_q & ~wb_stall;
  assign has_ex = int_pend | (|wb_ex_q);

  // ex bit order: {ades, adel_ld, bp, sys, ov, ri, adel_if}
  always_comb begin
    excode = 5'd0;
    bv_we  = 1'b0;
    bv     = '0;
    if (int_pend)        excode = 5'd0;
    else if (wb_ex_q[0]) begin excode = 5'd4; bv_we = 1'b1; bv = wb_pc_q; end
    else if (wb_ex_q[1]) excode = 5'd10;
    else if (wb_ex_q[2]) excode = 5'd12;
    else if (wb_ex_q[3]) excode = 5'd8;
    else if (wb_ex_q[4]) excode = 5'd9;
    else if (wb_ex_q[5]) begin excode = 5'd4; bv_we = 1'b1; bv = wb_badvaddr_q; end
    else if (wb_ex_q[6]) begin excode = 5'd5; bv_we = 1'b1; bv = wb_badvaddr_q; end
  end

  assign wb_except      = commit & has_ex;
  assign wb_excode      = wb_except ? excode : 5'd0;
  assign wb_bd          = wb_except & wb_bd_q;
  assign wb_pc          = wb_except ? (wb_bd_q ? wb_pc_q - 32'd4 : wb_pc_q) : 32'd0;
  assign wb_badvaddr_we = wb_except & bv_we;
  assign wb_badvaddr    = wb_badvaddr_we ? bv : 32'd0;
  assign eret_flush     = commit & wb_eret_q & ~has_ex;
  assign mtc0_we        = commit & wb_mtc0_q & ~has_ex;
  assign c0_addr        = mtc0_we ? wb_c0_addr_q : 8'd0;
  assign c0_wdata       = mtc0_we ? wb_wdata_q : 32'd0;
  assign flush          = wb_except | eret_flush;
  assign flush_target   = eret_flush ? c0_epc : (c0_status_bev ? EX_VEC_BEV1 : EX_VEC_BEV0);

  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // DRAIN waits out a stall so the stale-path instruction is still discarded.
  always_comb begin
    state_next = state;
    case (state)
      RUN:     if (flush) state_next = DRAIN;
      DRAIN:   if (!wb_stall) state_next = RUN;
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    drain     = (state == DRAIN);
    dbg_state = state;
  end

endmodule

// File: tb/tb_except_commit.sv
// Directed bench for except_commit; expectations follow EXCEPT_COMMIT_INT_EN when it is defined.
module tb_except_commit;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_valid, mem_bd, mem_eret, mem_mtc0;
  logic [31:0] mem_pc, mem_c0_wdata, mem_badvaddr;
  logic [7:0]  mem_c0_addr;
  logic [6:0]  mem_ex;
  logic        wb_stall;
  logic        c0_status_ie, c0_status_exl, c0_status_bev;
  logic [7:0]  c0_status_im, c0_cause_ip;
  logic [31:0] c0_epc;
  logic        wb_except, wb_bd, wb_badvaddr_we, eret_flush, mtc0_we, flush, dbg_state;
  logic [4:0]  wb_excode;
  logic [31:0] wb_pc, wb_badvaddr, c0_wdata, flush_target;
  logic [7:0]  c0_addr;

  int n_checks = 0;
  int n_fail   = 0;

  except_commit dut (
    .clk(clk), .reset(reset),
    .mem_valid(mem_valid), .mem_pc(mem_pc), .mem_bd(mem_bd), .mem_eret(mem_eret),
    .mem_mtc0(mem_mtc0), .mem_c0_addr(mem_c0_addr), .mem_c0_wdata(mem_c0_wdata),
    .mem_ex(mem_ex), .mem_badvaddr(mem_badvaddr), .wb_stall(wb_stall),
    .c0_status_ie(c0_status_ie), .c0_status_exl(c0_status_exl), .c0_status_bev(c0_status_bev),
    .c0_status_im(c0_status_im), .c0_cause_ip(c0_cause_ip), .c0_epc(c0_epc),
    .wb_except(wb_except), .wb_excode(wb_excode), .wb_bd(wb_bd), .wb_pc(wb_pc),
    .wb_badvaddr(wb_badvaddr), .wb_badvaddr_we(wb_badvaddr_we), .eret_flush(eret_flush),
    .mtc0_we(mtc0_we), .c0_addr(c0_addr), .c0_wdata(c0_wdata), .flush(flush),
    .flush_target(flush_target), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0; mem_pc = '0; mem_bd = 1'b0; mem_eret = 1'b0; mem_mtc0 = 1'b0;
    mem_c0_addr = '0; mem_c0_wdata = '0; mem_ex = '0; mem_badvaddr = '0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic bd, input logic eret, input logic mtc0,
                       input logic [7:0] addr, input logic [31:0] wd, input logic [6:0] ex,
                       input logic [31:0] bva);
    mem_valid = 1'b1; mem_pc = pc; mem_bd = bd; mem_eret = eret; mem_mtc0 = mtc0;
    mem_c0_addr = addr; mem_c0_wdata = wd; mem_ex = ex; mem_badvaddr = bva;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_except"}, {31'd0, wb_except}, 32'd0);
    chk({tag, "_flush"}, {31'd0, flush}, 32'd0);
    chk({tag, "_eret"}, {31'd0, eret_flush}, 32'd0);
    chk({tag, "_mtc0"}, {31'd0, mtc0_we}, 32'd0);
    chk({tag, "_excode"}, {27'd0, wb_excode}, 32'd0);
    chk({tag, "_bvwe"}, {31'd0, wb_badvaddr_we}, 32'd0);
    chk({tag, "_pc"}, wb_pc, 32'd0);
  endtask

  initial begin
    reset = 1'b1; wb_stall = 1'b0; idle();
    c0_status_ie = 1'b0; c0_status_exl = 1'b0; c0_status_bev = 1'b1;
    c0_status_im = '0; c0_cause_ip = '0; c0_epc = '0;
    tick(); tick();
    #1;
    chk_quiet("rst");
    chk("rst_target", flush_target, 32'hBFC00380);
    chk("rst_state", {31'd0, dbg_state}, 32'd0);
    reset = 1'b0;

    // plain ADD
    issue(32'hBFC00010, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0000000, 32'h0);
    tick(); idle(); #1;
    chk_quiet("add");

    // RI in delay slot; stale-path instructions carrying sys/bp must be dropped
    issue(32'hBFC00020, 1'b1, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0000010, 32'h0);
    tick();
    issue(32'hBFC00024, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0001000, 32'h0);
    #1;
    chk("ri_except", {31'd0, wb_except}, 32'd1);
    chk("ri_excode", {27'd0, wb_excode}, 32'd10);
    chk("ri_bd", {31'd0, wb_bd}, 32'd1);
    chk("ri_pc", wb_pc, 32'hBFC0001C);
    chk("ri_flush", {31'd0, flush}, 32'd1);
    chk("ri_target", flush_target, 32'hBFC00380);
    chk("ri_bvwe", {31'd0, wb_badvaddr_we}, 32'd0);
    tick();
    issue(32'hBFC00028, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0010000, 32'h0);
    #1;
    chk("drain_state", {31'd0, dbg_state}, 32'd1);
    chk_quiet("drain1");
    tick(); idle(); #1;
    chk("drain_back", {31'd0, dbg_state}, 32'd0);
    chk_quiet("drain2");

    // adel_ld with BEV=0
    c0_status_bev = 1'b0;
    issue(32'h80001000, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0100000, 32'h80000003);
    tick(); idle(); #1;
    chk("ld_excode", {27'd0, wb_excode}, 32'd4);
    chk("ld_bvwe", {31'd0, wb_badvaddr_we}, 32'd1);
    chk("ld_bv", wb_badvaddr, 32'h80000003);
    chk("ld_target", flush_target, 32'h80000180);
    chk("ld_pc", wb_pc, 32'h80001000);
    tick(); tick();
    c0_status_bev = 1'b1;

    // adel_if beats ri and ades; BadVAddr is the PC
    issue(32'hBFC00040, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b1000011, 32'h12340000);
    tick(); idle(); #1;
    chk("if_excode", {27'd0, wb_excode}, 32'd4);
    chk("if_bv", wb_badvaddr, 32'hBFC00040);
    chk("if_bvwe", {31'd0, wb_badvaddr_we}, 32'd1);
    tick(); tick();

    // ov beats sys and bp
    issue(32'hBFC00044, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0011100, 32'h0);
    tick(); idle(); #1;
    chk("ov_excode", {27'd0, wb_excode}, 32'd12);
    tick(); tick();

    // sys beats bp
    issue(32'hBFC00048, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0011000, 32'h0);
    tick(); idle(); #1;
    chk("sys_excode", {27'd0, wb_excode}, 32'd8);
    tick(); tick();

    // ades alone
    issue(32'hBFC0004C, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b1000000, 32'h80000006);
    tick(); idle(); #1;
    chk("ades_excode", {27'd0, wb_excode}, 32'd5);
    chk("ades_bv", wb_badvaddr, 32'h80000006);
    tick(); tick();

    // interrupt on an MTC0
    c0_status_ie = 1'b1; c0_status_im = 8'h80; c0_cause_ip = 8'h80;
    issue(32'hBFC00050, 1'b0, 1'b0, 1'b1, 8'h60, 32'h12345678, 7'b0000000, 32'h0);
    tick(); idle(); #1;
`ifdef EXCEPT_COMMIT_INT_EN
    chk("int_except", {31'd0, wb_except}, 32'd1);
    chk("int_excode", {27'd0, wb_excode}, 32'd0);
    chk("int_mtc0", {31'd0, mtc0_we}, 32'd0);
    chk("int_flush", {31'd0, flush}, 32'd1);
`else
    chk("int_except", {31'd0, wb_except}, 32'd0);
    chk("int_mtc0", {31'd0, mtc0_we}, 32'd1);
    chk("int_addr", {24'd0, c0_addr}, 32'h60);
    chk("int_wdata", c0_wdata, 32'h12345678);
`endif
    tick(); tick();

    // interrupt together with adel_if
    issue(32'hBFC00058, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0000001, 32'h0);
    tick(); idle(); #1;
`ifdef EXCEPT_COMMIT_INT_EN
    chk("intif_excode", {27'd0, wb_excode}, 32'd0);
    chk("intif_bvwe", {31'd0, wb_badvaddr_we}, 32'd0);
`else
    chk("intif_excode", {27'd0, wb_excode}, 32'd4);
    chk("intif_bvwe", {31'd0, wb_badvaddr_we}, 32'd1);
`endif
    chk("intif_except", {31'd0, wb_except}, 32'd1);
    c0_status_ie = 1'b0; c0_status_im = '0; c0_cause_ip = '0;
    tick(); tick();

    // plain MTC0 commits
    issue(32'hBFC0005C, 1'b0, 1'b0, 1'b1, 8'h68, 32'hCAFEBABE, 7'b0000000, 32'h0);
    tick(); idle(); #1;
    chk("mtc0_we", {31'd0, mtc0_we}, 32'd1);
    chk("mtc0_addr", {24'd0, c0_addr}, 32'h68);
    chk("mtc0_wdata", c0_wdata, 32'hCAFEBABE);
    chk("mtc0_flush", {31'd0, flush}, 32'd0);

    // ERET held by a 3-cycle stall; a sys instruction waits in MEM meanwhile
    c0_epc = 32'hBFC00100;
    issue(32'hBFC00060, 1'b0, 1'b1, 1'b0, 8'h00, 32'h0, 7'b0000000, 32'h0);
    tick();
    wb_stall = 1'b1;
    issue(32'hBFC00064, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0001000, 32'h0);
    #1;
    chk_quiet("stall1");
    tick(); chk_quiet("stall2");
    tick(); chk_quiet("stall3");
    tick();
    wb_stall = 1'b0;
    #1;
    chk("eret_flush", {31'd0, eret_flush}, 32'd1);
    chk("eret_flushsig", {31'd0, flush}, 32'd1);
    chk("eret_target", flush_target, 32'hBFC00100);
    chk("eret_except", {31'd0, wb_except}, 32'd0);
    tick(); idle(); #1;
    chk("eret_drain", {31'd0, dbg_state}, 32'd1);
    chk_quiet("eret_drop");
    tick();

    // reset asserted during DRAIN
    issue(32'hBFC00070, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0001000, 32'h0);
    tick(); idle(); #1;
    chk("pre_rst_excode", {27'd0, wb_excode}, 32'd8);
    tick();
    chk("pre_rst_state", {31'd0, dbg_state}, 32'd1);
    reset = 1'b1;
    issue(32'hBFC00074, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0, 7'b0010000, 32'h0);
    tick(); #1;
    chk("mid_rst_state", {31'd0, dbg_state}, 32'd0);
    chk_quiet("mid_rst");
    chk("mid_rst_target", flush_target, 32'hBFC00380);
    reset = 1'b0; idle();
    tick(); #1;
    chk_quiet("post_rst");

    // final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
